// File: rtl/hazard_pkg.sv
// Shared defaults and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned NFWD_DEF    = 2;
    localparam int unsigned CSR_MAX_DEF = 3;
    localparam int unsigned REG_IDX_W   = $clog2(NREG_DEF);
    localparam int unsigned STALL_W     = 32;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_prio_sel.sv
// Forwarding priority select for one EX source: one-hot pick of the youngest
// forwarding stage holding a write to that source register.
module fwd_prio_sel
    import hazard_pkg::*;
#(
    parameter int unsigned NFWD  = NFWD_DEF,
    parameter int unsigned IDX_W = REG_IDX_W
) (
    input  logic [IDX_W-1:0]      src,
    input  logic                  src_xrs,
    input  logic [NFWD*IDX_W-1:0] fwd_rd,
    input  logic [NFWD-1:0]       fwd_w_en,
    output logic [NFWD-1:0]       sel_c
);

    logic [NFWD-1:0] hit;

    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            hit[k] = src_xrs && (src != '0) && fwd_w_en[k]
                     && (fwd_rd[k*IDX_W +: IDX_W] == src);
        end
    end

    // Lowest index is the youngest stage; isolate the lowest set bit.
    assign sel_c = hit & (~hit + NFWD'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use and CSR interlocks, EX forwarding
// selects and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned NFWD    = NFWD_DEF,
    parameter int unsigned CSR_MAX = CSR_MAX_DEF,
    localparam int unsigned IDX_W  = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      id_rs1,
    input  logic [IDX_W-1:0]      id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [IDX_W-1:0]      id_rd,
    input  logic                  id_rd_w_en,
    input  logic                  id_is_load,
    input  logic                  id_csr_r,
    input  logic                  id_csr_w,
    input  logic                  id_fire,
    input  logic                  flush,
    input  logic [IDX_W-1:0]      ex_rs1,
    input  logic [IDX_W-1:0]      ex_rs2,
    input  logic                  ex_src1_xrs1,
    input  logic                  ex_src2_xrs2,
    input  logic [NFWD*IDX_W-1:0] fwd_rd,
    input  logic [NFWD-1:0]       fwd_w_en,
    input  logic                  ld_ret_valid,
    input  logic [IDX_W-1:0]      ld_ret_rd,
    input  logic                  csr_retire,
    output logic [NFWD-1:0]       fwd_src1_sel,
    output logic [NFWD-1:0]       fwd_src2_sel,
    output logic                  if_id_stall,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam int unsigned CNT_W = cnt_width(CSR_MAX);

    logic [NREG-1:1]    ld_pend;
    logic [NREG-1:1]    ld_pend_nxt;
    logic [NREG-1:0]    pend_vec;
    logic [CNT_W-1:0]   csr_cnt;
    logic [CNT_W-1:0]   csr_cnt_nxt;
    logic [STALL_W-1:0] stall_cnt_nxt;
    logic               fire;
    logic               ld_set;
    logic               csr_inc;
    logic               csr_full;
    logic               csr_busy;

    // x0 never has a pending load, so its bit is a constant zero.
    assign pend_vec = {ld_pend, 1'b0};

    assign csr_full = (csr_cnt == CNT_W'(CSR_MAX));
    assign csr_busy = (csr_cnt != '0);

    assign if_id_stall = (id_rs1_used && pend_vec[id_rs1])
                      || (id_rs2_used && pend_vec[id_rs2])
                      || (id_csr_r && csr_busy)
                      || (id_csr_w && csr_full);

    // A fire request raised during a stall is not a real transfer.
    assign fire    = id_fire && !flush && !if_id_stall;
    assign ld_set  = fire && id_is_load && id_rd_w_en && (id_rd != '0);
    assign csr_inc = fire && id_csr_w;

    // Load-pending update; a new load to the same rd beats a return.
    always_comb begin
        ld_pend_nxt = ld_pend;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (ld_set && (id_rd == IDX_W'(i))) begin
                ld_pend_nxt[i] = 1'b1;
            end else if (ld_ret_valid && (ld_ret_rd == IDX_W'(i))) begin
                ld_pend_nxt[i] = 1'b0;
            end
        end
    end

    // In-flight CSR write count; an issue and a retire together cancel out.
    always_comb begin
        csr_cnt_nxt = csr_cnt;
        if (csr_inc && !csr_retire) begin
            if (!csr_full) begin
                csr_cnt_nxt = csr_cnt + CNT_W'(1);
            end
        end else if (csr_retire && !csr_inc) begin
            if (csr_busy) begin
                csr_cnt_nxt = csr_cnt - CNT_W'(1);
            end
        end
    end

    assign stall_cnt_nxt = (if_id_stall && (stall_cnt != '1))
                         ? stall_cnt + STALL_W'(1)
                         : stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pend   <= '0;
            csr_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            ld_pend   <= ld_pend_nxt;
            csr_cnt   <= csr_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    fwd_prio_sel #(
        .NFWD  (NFWD),
        .IDX_W (IDX_W)
    ) u_fwd_src1 (
        .src      (ex_rs1),
        .src_xrs  (ex_src1_xrs1),
        .fwd_rd   (fwd_rd),
        .fwd_w_en (fwd_w_en),
        .sel_c    (fwd_src1_sel)
    );

    fwd_prio_sel #(
        .NFWD  (NFWD),
        .IDX_W (IDX_W)
    ) u_fwd_src2 (
        .src      (ex_rs2),
        .src_xrs  (ex_src2_xrs2),
        .fwd_rd   (fwd_rd),
        .fwd_w_en (fwd_w_en),
        .sel_c    (fwd_src2_sel)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic compared every cycle against a set/count based reference model.
module tb_hazard_scoreboard;

    localparam int unsigned NREG    = 32;
    localparam int unsigned NFWD    = 2;
    localparam int unsigned CSR_MAX = 3;
    localparam int unsigned IW      = 5;
    localparam logic [63:0] SAT     = 64'h0000_0000_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IW-1:0]     id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ld_ret_rd;
    logic              id_rs1_used, id_rs2_used, id_rd_w_en, id_is_load;
    logic              id_csr_r, id_csr_w, id_fire, flush;
    logic              ex_src1_xrs1, ex_src2_xrs2, ld_ret_valid, csr_retire;
    logic [NFWD*IW-1:0] fwd_rd;
    logic [NFWD-1:0]   fwd_w_en, fwd_src1_sel, fwd_src2_sel;
    logic              if_id_stall;
    logic [31:0]       stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          pend_m[NREG];
    int          csr_m;
    logic [63:0] stall_m;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG    (NREG),
        .NFWD    (NFWD),
        .CSR_MAX (CSR_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rd_w_en   (id_rd_w_en),
        .id_is_load   (id_is_load),
        .id_csr_r     (id_csr_r),
        .id_csr_w     (id_csr_w),
        .id_fire      (id_fire),
        .flush        (flush),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_src1_xrs1 (ex_src1_xrs1),
        .ex_src2_xrs2 (ex_src2_xrs2),
        .fwd_rd       (fwd_rd),
        .fwd_w_en     (fwd_w_en),
        .ld_ret_valid (ld_ret_valid),
        .ld_ret_rd    (ld_ret_rd),
        .csr_retire   (csr_retire),
        .fwd_src1_sel (fwd_src1_sel),
        .fwd_src2_sel (fwd_src2_sel),
        .if_id_stall  (if_id_stall),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) pend_m[i] = 1'b0;
        csr_m   = 0;
        stall_m = 64'd0;
    endtask

    function automatic logic model_stall();
        return (id_rs1_used && pend_m[id_rs1]) || (id_rs2_used && pend_m[id_rs2])
            || (id_csr_r && csr_m != 0) || (id_csr_w && csr_m == int'(CSR_MAX));
    endfunction

    // Youngest (lowest index) matching stage wins; scan oldest to youngest.
    function automatic logic [NFWD-1:0] model_sel(input logic [IW-1:0] rs, input logic xrs);
        logic [NFWD-1:0] s;
        s = '0;
        if (xrs && rs != '0) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_w_en[k] && fwd_rd[k*IW +: IW] == rs) begin
                    s    = '0;
                    s[k] = 1'b1;
                end
            end
        end
        return s;
    endfunction

    task automatic compare_outputs();
        #1;
        chk("if_id_stall", 64'(if_id_stall), 64'(model_stall()));
        chk("fwd_src1_sel", 64'(fwd_src1_sel), 64'(model_sel(ex_rs1, ex_src1_xrs1)));
        chk("fwd_src2_sel", 64'(fwd_src2_sel), 64'(model_sel(ex_rs2, ex_src2_xrs2)));
        chk("stall_cnt", 64'(stall_cnt), stall_m);
    endtask

    // Apply this cycle's inputs to the model, then move to the next negedge.
    task automatic advance();
        logic st, fire_e, inc;
        st     = model_stall();
        fire_e = id_fire && !st && !flush;
        if (ld_ret_valid) pend_m[ld_ret_rd] = 1'b0;
        if (fire_e && id_is_load && id_rd_w_en && id_rd != '0) pend_m[id_rd] = 1'b1;
        inc = fire_e && id_csr_w;
        if (inc && !csr_retire && csr_m < int'(CSR_MAX)) csr_m++;
        else if (!inc && csr_retire && csr_m > 0) csr_m--;
        if (st && stall_m != SAT) stall_m++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rs1 = '0; ex_rs2 = '0; ld_ret_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; id_rd_w_en = 0; id_is_load = 0;
        id_csr_r = 0; id_csr_w = 0; id_fire = 0; flush = 0;
        ex_src1_xrs1 = 0; ex_src2_xrs2 = 0; ld_ret_valid = 0; csr_retire = 0;
        fwd_rd = '0; fwd_w_en = '0;
    endtask

    task automatic issue_load(input logic [IW-1:0] rd);
        clear_inputs();
        id_rd = rd; id_is_load = 1; id_rd_w_en = 1; id_fire = 1;
        compare_outputs();
        advance();
    endtask

    task automatic randomize_inputs();
        id_rs1       = IW'($urandom_range(7));
        id_rs2       = IW'($urandom_range(7));
        id_rd        = IW'($urandom_range(7));
        id_rs1_used  = 1'($urandom_range(1));
        id_rs2_used  = 1'($urandom_range(1));
        id_rd_w_en   = ($urandom_range(3) != 0);
        id_is_load   = ($urandom_range(2) == 0);
        id_csr_r     = ($urandom_range(7) == 0);
        id_csr_w     = ($urandom_range(5) == 0);
        flush        = ($urandom_range(7) == 0);
        ex_rs1       = IW'($urandom_range(7));
        ex_rs2       = IW'($urandom_range(7));
        ex_src1_xrs1 = ($urandom_range(3) != 0);
        ex_src2_xrs2 = ($urandom_range(3) != 0);
        for (int k = 0; k < NFWD; k++) fwd_rd[k*IW +: IW] = IW'($urandom_range(7));
        fwd_w_en     = NFWD'($urandom_range((1 << NFWD) - 1));
        ld_ret_valid = ($urandom_range(2) == 0);
        ld_ret_rd    = IW'($urandom_range(7));
        csr_retire   = ($urandom_range(5) == 0);
        // Upstream normally holds fire low while stalled; occasionally it does not.
        id_fire      = model_stall() ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        // Reset state with a pending-csr-write request present
        id_csr_w = 1; id_rs1 = 5; id_rs1_used = 1;
        #1;
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_if_id_stall", 64'(if_id_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // Load-use stall on x5 until the return cycle
        issue_load(5'd5);
        clear_inputs();
        id_rs1 = 5; id_rs1_used = 1;
        compare_outputs();
        chk("ld_use_stall_c1", 64'(if_id_stall), 64'd1);
        advance();
        compare_outputs();
        advance();
        ld_ret_valid = 1; ld_ret_rd = 5;
        compare_outputs();
        chk("ld_use_stall_ret_cycle", 64'(if_id_stall), 64'd1);
        advance();
        ld_ret_valid = 0;
        compare_outputs();
        chk("ld_use_released", 64'(if_id_stall), 64'd0);
        chk("ld_use_stall_cnt", 64'(stall_cnt), 64'd3);
        advance();

        // Forwarding priority
        clear_inputs();
        fwd_w_en = 2'b11; fwd_rd = {5'd7, 5'd7}; ex_rs1 = 7; ex_src1_xrs1 = 1;
        compare_outputs();
        chk("fwd_youngest", 64'(fwd_src1_sel), 64'h1);
        ex_rs1 = 0;
        #1;
        chk("fwd_x0", 64'(fwd_src1_sel), 64'h0);
        ex_rs1 = 7; fwd_w_en = 2'b10; ex_rs2 = 7; ex_src2_xrs2 = 1;
        #1;
        chk("fwd_older_only", 64'(fwd_src1_sel), 64'h2);
        chk("fwd_src2_older", 64'(fwd_src2_sel), 64'h2);
        advance();

        // Load issue and return to x9 in one cycle: set wins
        clear_inputs();
        id_rd = 9; id_is_load = 1; id_rd_w_en = 1; id_fire = 1;
        ld_ret_valid = 1; ld_ret_rd = 9;
        compare_outputs();
        advance();
        clear_inputs();
        id_rs2 = 9; id_rs2_used = 1;
        compare_outputs();
        chk("set_wins_x9", 64'(if_id_stall), 64'd1);
        advance();
        clear_inputs();
        ld_ret_valid = 1; ld_ret_rd = 9;
        compare_outputs();
        advance();

        // CSR write limit and CSR read interlock
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            id_csr_w = 1; id_fire = 1;
            compare_outputs();
            advance();
        end
        clear_inputs();
        id_csr_w = 1;
        compare_outputs();
        chk("csr_fourth_w_stall", 64'(if_id_stall), 64'd1);
        advance();
        clear_inputs();
        id_csr_r = 1;
        for (int i = 0; i < 3; i++) begin
            csr_retire = 1;
            compare_outputs();
            chk("csr_r_waits", 64'(if_id_stall), 64'd1);
            advance();
        end
        csr_retire = 1;
        compare_outputs();
        chk("csr_r_released", 64'(if_id_stall), 64'd0);
        advance();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            compare_outputs();
            advance();
        end

        // Saturation: preload the counter near the top under continuous stall
        issue_load(5'd4);
        clear_inputs();
        id_rs1 = 4; id_rs1_used = 1;
        compare_outputs();
        force dut.stall_cnt_nxt = 32'hFFFF_FFFD;
        advance();
        release dut.stall_cnt_nxt;
        stall_m = 64'h0000_0000_FFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            compare_outputs();
            advance();
        end
        #1;
        chk("stall_cnt_saturated", 64'(stall_cnt), SAT);

        // Asynchronous reset mid-cycle with a load pending on x3
        @(negedge clk);
        issue_load(5'd3);
        clear_inputs();
        id_rs1 = 3; id_rs1_used = 1;
        compare_outputs();
        chk("pre_reset_x3_stall", 64'(if_id_stall), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", 64'(if_id_stall), 64'd0);
        chk("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
